wb_result_pipe: RTL and testbench

Parametrised, registered successor to the RV32I writeback result select. Chooses one of NSRC result sources (ALU, load data, PC+4, immediate, PC+imm, …) by a select code and zero-forces writes to x0. Buffers the chosen result with its destination register in a 2-entry skid buffer using a valid/ready handshake, so the writeback stage can stall without losing results. Sits between the execute/memory stages and the register-file write port.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_skid_buf.sv | 62 ++++++
 rtl/wb_result_pipe.sv | 89 ++++++++
 tb/tb_wb_result_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: result-source select codes, default sizes and the buffered entry.
package wb_pkg;

    localparam int unsigned WB_WIDTH = 32;
    localparam int unsigned WB_NSRC  = 5;
    localparam int unsigned WB_RD_W  = 5;

    typedef enum logic [2:0] {
        SEL_ALU   = 3'd0,
        SEL_MEM   = 3'd1,
        SEL_PC4   = 3'd2,
        SEL_IMM   = 3'd3,
        SEL_PCIMM = 3'd4
    } wb_sel_e;

    typedef struct packed {
        logic [WB_WIDTH-1:0] data;
        logic [WB_RD_W-1:0]  rd;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Generic in-order 2-entry valid/ready FIFO; the head entry drives out_data straight from a register.
module wb_skid_buf #(
    parameter int unsigned DW = 37
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    r_count;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic          w_push;
    logic          w_pop;

    // Full means no push, even if a pop frees a slot this cycle.
    assign in_ready  = (r_count != 2'd2) && !rst;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= in_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= in_data;
                    end else if (w_push) begin
                        r_tail  <= in_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/wb_result_pipe.sv
// Registered writeback result select with x0 forcing and a 2-entry skid buffer.
// Define WB_RESULT_ILLEGAL_TRAP_EN to drop illegal-select bundles and raise a sticky err.
module wb_result_pipe
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = WB_WIDTH,
    parameter int unsigned NSRC  = WB_NSRC,
    parameter int unsigned SEL_W = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic [4:0]            rd_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [4:0]            out_rd,
    output logic                  err
);

    localparam int unsigned ENTRY_W = WIDTH + 5;

    logic [WIDTH-1:0]   w_sel_data;
    logic [WIDTH-1:0]   w_wr_data;
    logic               w_push_valid;
    logic [ENTRY_W-1:0] w_buf_in;
    logic [ENTRY_W-1:0] w_buf_out;

`ifdef WB_RESULT_ILLEGAL_TRAP_EN
    logic w_sel_legal;
    logic r_err;
`endif

    // Out-of-range select codes match no source and leave the result at zero.
    always_comb begin
        w_sel_data = '0;
`ifdef WB_RESULT_ILLEGAL_TRAP_EN
        w_sel_legal = 1'b0;
`endif
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = src_data[k*WIDTH +: WIDTH];
`ifdef WB_RESULT_ILLEGAL_TRAP_EN
                w_sel_legal = 1'b1;
`endif
            end
        end
    end

    assign w_wr_data = (rd_addr == 5'd0) ? '0 : w_sel_data;
    assign w_buf_in  = {w_wr_data, rd_addr};

`ifdef WB_RESULT_ILLEGAL_TRAP_EN
    assign w_push_valid = in_valid && w_sel_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (in_valid && in_ready && !w_sel_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_push_valid = in_valid;
    assign err          = 1'b0;
`endif

    wb_skid_buf #(
        .DW(ENTRY_W)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w_push_valid),
        .in_ready (in_ready),
        .in_data  (w_buf_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_buf_out)
    );

    assign out_data = w_buf_out[ENTRY_W-1:5];
    assign out_rd   = w_buf_out[4:0];

endmodule

// File: tb/tb_wb_result_pipe.sv
// Directed self-checking bench for wb_result_pipe at default parameters.
module tb_wb_result_pipe;
    import wb_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] src_data;
    logic [2:0]   sel;
    logic [4:0]   rd_addr;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [4:0]   out_rd;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    wb_result_pipe u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src_data (src_data),
        .sel      (sel),
        .rd_addr  (rd_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_rd   (out_rd),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] pack5(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] e);
        return {e, d, c, b, a};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        src_data  = '0;
        sel       = '0;
        rd_addr   = '0;
        out_ready = 1'b0;

        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Pass-through
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = SEL_ALU;
        src_data  = pack5(32'h0000_1234, 32'h1, 32'h2, 32'h3, 32'h4);
        rd_addr   = 5'd5;
        tick();
        in_valid = 1'b0;
        check("pt_valid", 64'(out_valid), 64'd1);
        check("pt_data", 64'(out_data), 64'h1234);
        check("pt_rd", 64'(out_rd), 64'd5);
        tick();
        check("pt_drained", 64'(out_valid), 64'd0);

        // All selects back to back
        src_data = pack5(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        rd_addr  = 5'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = 3'(i);
            tick();
            check($sformatf("sel%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("sel%0d_data", i), 64'(out_data), 64'(32'hA0 + i));
            check($sformatf("sel%0d_rd", i), 64'(out_rd), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("sel_drained", 64'(out_valid), 64'd0);

        // x0 suppression
        in_valid = 1'b1;
        sel      = SEL_MEM;
        src_data = pack5(32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        rd_addr  = 5'd0;
        tick();
        in_valid = 1'b0;
        check("x0_valid", 64'(out_valid), 64'd1);
        check("x0_data", 64'(out_data), 64'd0);
        check("x0_rd", 64'(out_rd), 64'd0);
        tick();

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = SEL_ALU;
        rd_addr   = 5'd2;
        src_data  = pack5(32'h11, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp1_in_ready", 64'(in_ready), 64'd1);
        check("bp1_data", 64'(out_data), 64'h11);
        src_data = pack5(32'h22, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp2_in_ready", 64'(in_ready), 64'd0);
        check("bp2_valid", 64'(out_valid), 64'd1);
        check("bp2_data", 64'(out_data), 64'h11);
        src_data = pack5(32'h33, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp_full_hold", 64'(out_data), 64'h11);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_pop1_data", 64'(out_data), 64'h22);
        check("bp_pop1_valid", 64'(out_valid), 64'd1);
        check("bp_pop1_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_no_33", 64'(out_valid), 64'd0);

        // Illegal select
        in_valid = 1'b1;
        sel      = 3'd7;
        rd_addr  = 5'd3;
        src_data = pack5(32'h5, 32'h6, 32'h7, 32'h8, 32'h9);
        tick();
        in_valid = 1'b0;
`ifdef WB_RESULT_ILLEGAL_TRAP_EN
        check("ill_valid", 64'(out_valid), 64'd0);
        check("ill_err", 64'(err), 64'd1);
        tick();
        check("ill_err_sticky", 64'(err), 64'd1);
`else
        check("ill_valid", 64'(out_valid), 64'd1);
        check("ill_data", 64'(out_data), 64'd0);
        check("ill_rd", 64'(out_rd), 64'd3);
        check("ill_err", 64'(err), 64'd0);
        tick();
`endif

        // Reset mid-stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = SEL_ALU;
        rd_addr   = 5'd4;
        src_data  = pack5(32'h55, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        src_data = pack5(32'h66, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        check("stall_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_rd", 64'(out_rd), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        check("post_arst_valid", 64'(out_valid), 64'd0);
        check("post_arst_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("post_arst_no_stale", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        rd_addr  = 5'd9;
        src_data = pack5(32'h77, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        check("post_arst_new_data", 64'(out_data), 64'h77);
        check("post_arst_new_rd", 64'(out_rd), 64'd9);
        tick();
        check("final_drained", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
